// File: rtl/hz_led_sequencer.sv
// hz_led_sequencer: synchronises the slow clk_Hz square wave, turns each rising
// edge into a one-cycle step pulse, and steps an LED pattern state machine
// (ping-pong, rotate-left, rotate-right, bar fill/clear).
// Optional build macro LED_ACTIVE_LOW_EN: led drives the inverted pattern
// (reset/IDLE value all ones); state, step and step_cnt are unaffected.
module hz_led_sequencer #(
  parameter int unsigned N_LED       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_Hz,
  input  logic             run,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic [7:0]       step_cnt
);

  localparam int unsigned CNT_W = 8;

  localparam logic [N_LED-1:0] PAT_ZERO = '0;
  localparam logic [N_LED-1:0] PAT_ONE  = N_LED'(1);
  localparam logic [N_LED-1:0] PAT_MSB  = {1'b1, {(N_LED-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PING_L   = 3'd1,
    S_PING_R   = 3'd2,
    S_ROT_L    = 3'd3,
    S_ROT_R    = 3'd4,
    S_BAR_FILL = 3'd5,
    S_BAR_CLR  = 3'd6
  } state_t;

  state_t                 state;
  state_t                 adv_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   hist;
  logic [N_LED-1:0]       pat;
  logic [N_LED-1:0]       adv_pat;
  logic [N_LED-1:0]       pat_shl;
  logic [N_LED-1:0]       pat_shr;
  logic [N_LED-1:0]       pat_rol;
  logic [N_LED-1:0]       pat_ror;
  logic [N_LED-1:0]       pat_fill;

  // Map the internal pattern to the led drive polarity.
  function automatic logic [N_LED-1:0] to_led(input logic [N_LED-1:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  // The led register is the only pattern storage; recover the pattern from it.
`ifdef LED_ACTIVE_LOW_EN
  assign pat = ~led;
`else
  assign pat = led;
`endif

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, edge history and registered rising-edge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist   <= 1'b0;
      step   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_Hz};
      hist   <= sync_out;
      step   <= sync_out & ~hist;
    end
  end

  assign pat_shl  = {pat[N_LED-2:0], 1'b0};
  assign pat_shr  = {1'b0, pat[N_LED-1:1]};
  assign pat_rol  = {pat[N_LED-2:0], pat[N_LED-1]};
  assign pat_ror  = {pat[0], pat[N_LED-1:1]};
  assign pat_fill = {pat[N_LED-2:0], 1'b1};

  // Next pattern and state for one step in the current running state.
  always_comb begin
    adv_pat   = pat;
    adv_state = state;
    case (state)
      S_PING_L: begin
        adv_pat = pat_shl;
        if (pat_shl[N_LED-1]) adv_state = S_PING_R;
      end
      S_PING_R: begin
        adv_pat = pat_shr;
        if (pat_shr[0]) adv_state = S_PING_L;
      end
      S_ROT_L:  adv_pat = pat_rol;
      S_ROT_R:  adv_pat = pat_ror;
      S_BAR_FILL: begin
        adv_pat = pat_fill;
        if (&pat_fill) adv_state = S_BAR_CLR;
      end
      S_BAR_CLR: begin
        adv_pat = pat_shl;
        if (~|pat_shl) adv_state = S_BAR_FILL;
      end
      default: begin
        adv_pat   = pat;
        adv_state = state;
      end
    endcase
  end

  // Pattern FSM: IDLE loads the start pattern, running states advance on step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      led      <= to_led(PAT_ZERO);
      step_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          led      <= to_led(PAT_ZERO);
          step_cnt <= '0;
          if (run) begin
            case (mode)
              2'b00: begin state <= S_PING_L;   led <= to_led(PAT_ONE);  end
              2'b01: begin state <= S_ROT_L;    led <= to_led(PAT_ONE);  end
              2'b10: begin state <= S_ROT_R;    led <= to_led(PAT_MSB);  end
              default: begin state <= S_BAR_FILL; led <= to_led(PAT_ZERO); end
            endcase
          end
        end
        default: begin
          if (!run) begin
            state    <= S_IDLE;
            led      <= to_led(PAT_ZERO);
            step_cnt <= '0;
          end else if (step) begin
            state    <= adv_state;
            led      <= to_led(adv_pat);
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hz_led_sequencer.sv
// Directed bench for hz_led_sequencer (N_LED=8, SYNC_STAGES=2).
// Expected led values go through exp_led so the bench also covers LED_ACTIVE_LOW_EN.
module tb_hz_led_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_Hz;
  logic       run;
  logic [1:0] mode;
  logic [7:0] led;
  logic       step;
  logic [7:0] step_cnt;

  int tests = 0;
  int fails = 0;
  int hz_div = 0;
  bit hz_run = 1'b0;

  logic [7:0] ping_exp [0:13] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] rol_exp  [0:8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h01, 8'h02};
  logic [7:0] ror_exp  [0:8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                  8'h80, 8'h40};
  logic [7:0] bar_exp  [0:15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  hz_led_sequencer #(.N_LED(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_Hz   (clk_Hz),
    .run      (run),
    .mode     (mode),
    .led      (led),
    .step     (step),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  // Expected led drive for a given internal pattern.
  function automatic logic [7:0] exp_led(input logic [7:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; clk_Hz toggles every 10 clk while hz_run.
  task automatic tick();
    @(negedge clk);
    if (hz_run) begin
      hz_div++;
      if (hz_div == 10) begin
        hz_div = 0;
        clk_Hz = ~clk_Hz;
      end
    end
  endtask

  // Wait for a step pulse, then one more cycle so the consuming edge has passed.
  task automatic next_step();
    int n = 0;
    while (step !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (step !== 1'b1) check("step_timeout", 32'(0), 32'(1));
    tick();
  endtask

  task automatic go_idle();
    run = 1'b0;
    tick();
  endtask

  initial begin
    // Reset held, clk_Hz low, run low.
    reset  = 1'b0;
    clk_Hz = 1'b0;
    run    = 1'b0;
    mode   = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'(exp_led(8'h00)));
    check("rst_cnt", 32'(step_cnt), 32'(0));
    check("rst_step", 32'(step), 32'(0));
    reset = 1'b1;
    repeat (3) tick();
    check("idle_led", 32'(led), 32'(exp_led(8'h00)));

    // Step latency: 3 cycles from first edge sampling clk_Hz=1, 1 cycle wide.
    clk_Hz = 1'b1;
    tick();
    check("lat_e1", 32'(step), 32'(0));
    tick();
    check("lat_e2", 32'(step), 32'(0));
    tick();
    check("lat_e3", 32'(step), 32'(1));
    tick();
    check("step_width", 32'(step), 32'(0));
    check("idle_cnt", 32'(step_cnt), 32'(0));
    hz_div = 0;
    hz_run = 1'b1;

    // Ping-pong.
    mode = 2'b00;
    run  = 1'b1;
    tick();
    check("ping_entry", 32'(led), 32'(exp_led(8'h01)));
    for (int i = 0; i < 14; i++) begin
      next_step();
      check($sformatf("ping_%0d", i), 32'(led), 32'(exp_led(ping_exp[i])));
    end
    check("ping_cnt14", 32'(step_cnt), 32'(14));
    hz_run = 1'b0;
    repeat (60) tick();
    check("hold_led", 32'(led), 32'(exp_led(8'h01)));
    check("hold_cnt", 32'(step_cnt), 32'(14));
    hz_run = 1'b1;
    next_step();
    check("ping_resume", 32'(led), 32'(exp_led(8'h02)));
    go_idle();
    check("ping_idle_led", 32'(led), 32'(exp_led(8'h00)));
    check("ping_idle_cnt", 32'(step_cnt), 32'(0));

    // Rotate left.
    mode = 2'b01;
    run  = 1'b1;
    tick();
    check("rol_entry", 32'(led), 32'(exp_led(8'h01)));
    for (int i = 0; i < 9; i++) begin
      next_step();
      check($sformatf("rol_%0d", i), 32'(led), 32'(exp_led(rol_exp[i])));
    end
    go_idle();

    // Rotate right.
    mode = 2'b10;
    run  = 1'b1;
    tick();
    check("ror_entry", 32'(led), 32'(exp_led(8'h80)));
    for (int i = 0; i < 9; i++) begin
      next_step();
      check($sformatf("ror_%0d", i), 32'(led), 32'(exp_led(ror_exp[i])));
    end
    check("ror_cnt9", 32'(step_cnt), 32'(9));
    go_idle();

    // Bar fill/clear and step_cnt wrap.
    mode = 2'b11;
    run  = 1'b1;
    tick();
    check("bar_entry", 32'(led), 32'(exp_led(8'h00)));
    for (int i = 1; i <= 257; i++) begin
      next_step();
      if (i <= 16) check($sformatf("bar_%0d", i), 32'(led), 32'(exp_led(bar_exp[i-1])));
      if (i == 255) check("cnt_255", 32'(step_cnt), 32'(255));
      if (i == 256) check("cnt_wrap0", 32'(step_cnt), 32'(0));
    end
    check("cnt_wrap1", 32'(step_cnt), 32'(1));
    check("bar_257", 32'(led), 32'(exp_led(8'h01)));
    go_idle();

    // Mode change mid-run ignored; run drop coinciding with a step wins.
    mode = 2'b00;
    run  = 1'b1;
    tick();
    next_step();
    check("mc_02", 32'(led), 32'(exp_led(8'h02)));
    mode = 2'b11;
    next_step();
    check("mc_04", 32'(led), 32'(exp_led(8'h04)));
    next_step();
    check("mc_08", 32'(led), 32'(exp_led(8'h08)));
    begin
      int n = 0;
      while (step !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      check("drop_step_seen", 32'(step), 32'(1));
    end
    run = 1'b0;
    tick();
    check("drop_led", 32'(led), 32'(exp_led(8'h00)));
    check("drop_cnt", 32'(step_cnt), 32'(0));
    next_step();
    check("idle_step_led", 32'(led), 32'(exp_led(8'h00)));
    check("idle_step_cnt", 32'(step_cnt), 32'(0));
    mode = 2'b01;
    run  = 1'b1;
    tick();
    check("resample_mode", 32'(led), 32'(exp_led(8'h01)));

    // Asynchronous reset mid-run.
    next_step();
    check("pre_rst", 32'(led), 32'(exp_led(8'h02)));
    #2 reset = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'(exp_led(8'h00)));
    check("async_rst_cnt", 32'(step_cnt), 32'(0));
    check("async_rst_step", 32'(step), 32'(0));
    run = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_led", 32'(led), 32'(exp_led(8'h00)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hz_led_sequencer.md
Name: hz_led_sequencer

Overview:
- Downstream consumer of the slow square-wave clk_Hz produced by the divider block.
- Synchronises clk_Hz into the system clock domain and converts each rising edge into a one-cycle step pulse.
- Each step advances an LED pattern state machine: ping-pong, rotate-left, rotate-right, or bar fill/clear.
- Everything runs in one clock domain; clk_Hz is treated as data, never as a clock.

Parameters:
N_LED, 8, LED vector width; legal range 2..32.
SYNC_STAGES, 2, flops in the clk_Hz synchroniser; legal range 2..4.

Ports:
clk  in  1  system clock (50 MHz board clock).
reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
clk_Hz  in  1  slow square wave from the divider; asynchronous to the sequencer logic.
run  in  1  level; 1 = sequence runs, 0 = return to IDLE.
mode  in  2  pattern select: 00 ping-pong, 01 rotate-left, 10 rotate-right, 11 bar.
led  out  N_LED  LED drive.
step  out  1  one-cycle pulse per synchronised rising edge of clk_Hz.
step_cnt  out  8  number of steps taken while running; wraps.

Behaviour:
- Reset (reset=0, async): synchroniser flops=0, edge-history flop=0, step=0, step_cnt=0, led=0, state=IDLE.
- Synchroniser: clk_Hz passes through SYNC_STAGES flops; the edge-history flop holds the previous synchronised value.
- step = sync_out & ~hist, registered.
  - Latency: SYNC_STAGES+1 clk cycles from the first clk edge sampling clk_Hz=1 to step=1.
  - step is exactly 1 cycle wide.
  - step pulses in every state, including IDLE.
- clk_Hz already 1 at reset release: produces exactly one step, SYNC_STAGES+1 cycles after release. This is intended.
- States: IDLE, PING_L, PING_R, ROT_L, ROT_R, BAR_FILL, BAR_CLR.
- IDLE:
  - led=0 and step_cnt held at 0.
  - When run=1, transition on the next clk edge without waiting for a step.
  - mode 00 -> PING_L, led=1.
  - mode 01 -> ROT_L, led=1.
  - mode 10 -> ROT_R, led=MSB only.
  - mode 11 -> BAR_FILL, led=0.
- mode is sampled only in IDLE. Changes while running are ignored until run falls.
- Running states update only on a cycle with step=1:
  - PING_L: led<<1; if the new led has its MSB set, go to PING_R.
  - PING_R: led>>1; if the new led has bit0 set, go to PING_L. The lit end bit is never skipped or doubled.
  - ROT_L: rotate left by 1, wrapping MSB into bit0.
  - ROT_R: rotate right by 1, wrapping bit0 into MSB.
  - BAR_FILL: led={led[N_LED-2:0],1}; when the new led is all ones, go to BAR_CLR.
  - BAR_CLR: led={led[N_LED-2:0],0}; when the new led is all zeros, go to BAR_FILL.
- step_cnt: +1 on each step taken in a running state; 8-bit wrap, 255 -> 0; cleared to 0 on entry to IDLE.
- run=0 in any running state: next edge -> IDLE, led=0, step_cnt=0.
  - If step=1 in the same cycle, the IDLE transition wins; no pattern advance and no count.
- run=1 with no steps: led holds indefinitely.
- Reset asserted mid-sequence: all outputs return to reset values immediately (async).
- led is fully registered; no combinational path from any input to led.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined:
  - The led port drives the bitwise inverse of the internal pattern.
  - Reset value of led is all ones; IDLE drives all ones.
  - Inversion is applied at the output register.
  - State, step and step_cnt are unchanged.
- Undefined: led drives the internal pattern directly (active-high); reset value is 0.

Test Plan:
All scenarios use N_LED=8, SYNC_STAGES=2; the bench toggles clk_Hz every 10 clk.
1. Reset held, then released with clk_Hz=0 and run=0 -> led=00, step_cnt=0; first step appears 3 cycles after the first clk edge sampling clk_Hz=1; step width 1 cycle.
2. mode=00, run=1 -> led=01 next cycle; steps give 02,04,...,80,40,...,01,02; step_cnt=14 after 14 steps.
3. mode=01, run=1, 9 steps -> led 01,02,...,80,01,02; mode=10 variant gives 80,40,...,01,80.
4. mode=11, run=1 -> led 00,01,03,...,FF,FE,FC,...,00,01; 257 steps -> step_cnt=1 (wrap).
5. run dropped in the same cycle as a step while led=08 -> next cycle led=00, step_cnt=0, state IDLE; a mode change applied mid-run has no effect.
6. LED_ACTIVE_LOW_EN defined, reset -> led=FF; mode=00 first run cycle -> led=FE; reset pulsed mid-run -> led=FF immediately.
